mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 160 ++++++++++++++++
 tb/tb_mem_access.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage of a 5-stage pipeline: passes ALU results to MEM/WB and runs loads/stores over a
// req/ack data bus. Define MEM_ALIGN_CHECK_EN to fault misaligned memory ops instead of issuing them.

package mem_access_pkg;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;
endpackage

module mem_access
   import mem_access_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  ex_alu_result,
   input  logic [XLEN-1:0]  ex_rs2_data,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_mem_write,
   output logic             mem_stall,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   input  logic             dmem_ack,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic [XLEN-1:0]  wb_data,
   output logic [REG_W-1:0] wb_rd,
   output logic             wb_reg_write,
   output logic             misaligned
);

   state_t           state, state_d;
   logic [XLEN-1:0]  hold_addr, hold_addr_d;
   logic [XLEN-1:0]  hold_wdata, hold_wdata_d;
   logic [REG_W-1:0] hold_rd, hold_rd_d;
   logic             hold_reg_write, hold_reg_write_d;
   logic             hold_store, hold_store_d;
   logic [XLEN-1:0]  wb_data_d;
   logic [REG_W-1:0] wb_rd_d;
   logic             wb_reg_write_d;
   logic             mem_op;
   logic             busy;

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned_d;
`endif

   assign mem_op = ex_mem_read | ex_mem_write;
   assign busy   = (state == BUSY);

   // Bus side is decoded from state and hold registers so reset clears it immediately
   assign mem_stall  = busy;
   assign dmem_req   = busy;
   assign dmem_we    = busy & hold_store;
   assign dmem_addr  = busy ? hold_addr  : '0;
   assign dmem_wdata = busy ? hold_wdata : '0;

   // State and MEM/WB register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         hold_addr      <= '0;
         hold_wdata     <= '0;
         hold_rd        <= '0;
         hold_reg_write <= 1'b0;
         hold_store     <= 1'b0;
         wb_data        <= '0;
         wb_rd          <= '0;
         wb_reg_write   <= 1'b0;
      end else begin
         state          <= state_d;
         hold_addr      <= hold_addr_d;
         hold_wdata     <= hold_wdata_d;
         hold_rd        <= hold_rd_d;
         hold_reg_write <= hold_reg_write_d;
         hold_store     <= hold_store_d;
         wb_data        <= wb_data_d;
         wb_rd          <= wb_rd_d;
         wb_reg_write   <= wb_reg_write_d;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   // One-cycle alignment fault pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misaligned <= 1'b0;
      end else begin
         misaligned <= misaligned_d;
      end
   end
`else
   assign misaligned = 1'b0;
`endif

   // Next-state and MEM/WB update
   always_comb begin
      state_d          = state;
      hold_addr_d      = hold_addr;
      hold_wdata_d     = hold_wdata;
      hold_rd_d        = hold_rd;
      hold_reg_write_d = hold_reg_write;
      hold_store_d     = hold_store;
      wb_data_d        = wb_data;
      wb_rd_d          = wb_rd;
      wb_reg_write_d   = wb_reg_write;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned_d     = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (mem_op) begin
`ifdef MEM_ALIGN_CHECK_EN
               if (ex_alu_result[1:0] != 2'b00) begin
                  wb_reg_write_d = 1'b0;
                  misaligned_d   = 1'b1;
               end else
`endif
               begin
                  state_d          = BUSY;
                  hold_addr_d      = {ex_alu_result[XLEN-1:2], 2'b00};
                  hold_wdata_d     = ex_rs2_data;
                  hold_rd_d        = ex_rd;
                  hold_reg_write_d = ex_reg_write;
                  // read+write together is a store
                  hold_store_d     = ex_mem_write;
                  wb_reg_write_d   = 1'b0;
               end
            end else begin
               wb_data_d      = ex_alu_result;
               wb_rd_d        = ex_rd;
               wb_reg_write_d = ex_reg_write;
            end
         end

         BUSY: begin
            if (dmem_ack) begin
               state_d = IDLE;
               if (hold_store) begin
                  wb_reg_write_d = 1'b0;
               end else begin
                  wb_data_d      = dmem_rdata;
                  wb_rd_d        = hold_rd;
                  wb_reg_write_d = hold_reg_write;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized checks of mem_access against a transaction-level model
// (expected MEM/WB contents plus a word-addressed memory image).

module tb_mem_access;

   logic        clk;
   logic        rst;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        misaligned;

   mem_access dut (
      .clk           (clk),
      .rst           (rst),
      .ex_alu_result (ex_alu_result),
      .ex_rs2_data   (ex_rs2_data),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .mem_stall     (mem_stall),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .wb_data       (wb_data),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .misaligned    (misaligned)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference model: what MEM/WB should hold, and the memory contents seen by loads
   logic [31:0] e_data;
   logic [4:0]  e_rd;
   logic        e_rw;
   logic [31:0] mem_img [logic [31:0]];

   // Op that the upstream pipeline holds on the inputs while the stage is stalled
   logic [31:0] nxt_res;
   logic [4:0]  nxt_rd;
   logic        nxt_rw;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_wb(input string tag);
      chk({tag, ".wb_data"}, wb_data, e_data);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(e_rd));
      chk({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(e_rw));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".mem_stall"}, 32'(mem_stall), 32'd0);
      chk({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
   endtask

   function automatic logic [31:0] mem_value(input logic [31:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // Pass-through op; optionally a stray ack arrives while idle
   task automatic drive_alu(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                            input logic stray_ack);
      ex_alu_result = res;
      ex_rs2_data   = $urandom;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      dmem_ack      = stray_ack;
      dmem_rdata    = $urandom;
      chk_idle("alu_pre");
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      e_data = res;
      e_rd   = rd;
      e_rw   = rw;
      chk_wb("alu");
      chk_idle("alu_post");
      chk("alu.misaligned", 32'(misaligned), 32'd0);
   endtask

   task automatic pick_next();
      nxt_res = $urandom;
      nxt_rd  = 5'($urandom_range(0, 31));
      nxt_rw  = 1'($urandom_range(0, 1));
   endtask

   // Memory op accepted from IDLE, completed after 'waits' ack-less cycles,
   // then followed immediately by the ALU op held upstream during the stall
   task automatic do_mem(input logic is_store, input logic both, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic rw,
                         input int waits);
      logic [31:0] word;
      logic [31:0] rval;
      word = {addr[31:2], 2'b00};
      ex_alu_result = addr;
      ex_rs2_data   = wdata;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_mem_write  = is_store;
      ex_mem_read   = is_store ? both : 1'b1;
      dmem_ack      = 1'b0;
      chk_idle("mem_pre");
      @(posedge clk); #1;
      pick_next();
      ex_alu_result = nxt_res;
      ex_rs2_data   = $urandom;
      ex_rd         = nxt_rd;
      ex_reg_write  = nxt_rw;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      e_rw = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if (addr[1:0] != 2'b00) begin
         chk("fault.dmem_req", 32'(dmem_req), 32'd0);
         chk("fault.mem_stall", 32'(mem_stall), 32'd0);
         chk("fault.misaligned", 32'(misaligned), 32'd1);
         chk_wb("fault");
         drive_alu(nxt_res, nxt_rd, nxt_rw, 1'b0);
         return;
      end
`endif
      for (int c = 0; c <= waits; c++) begin
         chk("busy.mem_stall", 32'(mem_stall), 32'd1);
         chk("busy.dmem_req", 32'(dmem_req), 32'd1);
         chk("busy.dmem_we", 32'(dmem_we), 32'(is_store));
         chk("busy.dmem_addr", dmem_addr, word);
         chk("busy.dmem_wdata", dmem_wdata, wdata);
         chk("busy.misaligned", 32'(misaligned), 32'd0);
         chk_wb("busy");
         rval = mem_value(word);
         if (c == waits) begin
            dmem_ack   = 1'b1;
            dmem_rdata = is_store ? $urandom : rval;
         end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
         end
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      if (is_store) begin
         mem_img[word] = wdata;
         e_rw = 1'b0;
      end else begin
         e_data = mem_value(word);
         e_rd   = rd;
         e_rw   = rw;
      end
      chk_wb("done");
      chk_idle("done");
      drive_alu(nxt_res, nxt_rd, nxt_rw, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".dmem_we"}, 32'(dmem_we), 32'd0);
      chk({tag, ".dmem_addr"}, dmem_addr, 32'd0);
      chk({tag, ".dmem_wdata"}, dmem_wdata, 32'd0);
      chk({tag, ".mem_stall"}, 32'(mem_stall), 32'd0);
      chk({tag, ".wb_data"}, wb_data, 32'd0);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'd0);
      chk({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'd0);
      chk({tag, ".misaligned"}, 32'(misaligned), 32'd0);
   endtask

   task automatic set_nop();
      ex_alu_result = '0;
      ex_rs2_data   = '0;
      ex_rd         = '0;
      ex_reg_write  = 1'b0;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          kind;
      rst        = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      set_nop();
      e_data = '0;
      e_rd   = '0;
      e_rw   = 1'b0;
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_wb("post_reset");

      // Directed scenarios
      drive_alu(32'h0000_0010, 5'd5, 1'b1, 1'b0);
      chk("pt.wb_data", wb_data, 32'h10);
      mem_img[32'h100] = 32'hDEAD_BEEF;
      do_mem(1'b0, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 0);
      do_mem(1'b1, 1'b0, 32'h200, 32'h1234_5678, 5'd9, 1'b1, 3);
      do_mem(1'b0, 1'b0, 32'h200, 32'h0, 5'd12, 1'b1, 1);
      do_mem(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 5'd2, 1'b1, 2);
      do_mem(1'b0, 1'b0, 32'h104, 32'h0, 5'd3, 1'b1, 0);
      drive_alu(32'hA5A5_0001, 5'd31, 1'b1, 1'b1);
      do_mem(1'b0, 1'b0, 32'h102, 32'h0, 5'd4, 1'b1, 0);

      // Reset during the second BUSY cycle abandons the load
      ex_alu_result = 32'h300;
      ex_rd         = 5'd3;
      ex_reg_write  = 1'b1;
      ex_mem_read   = 1'b1;
      ex_mem_write  = 1'b0;
      @(posedge clk); #1;
      set_nop();
      chk("rst_b1.dmem_req", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      chk("rst_b2.dmem_req", 32'(dmem_req), 32'd1);
      #2;
      rst        = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      #1;
      e_data = '0;
      e_rd   = '0;
      e_rw   = 1'b0;
      chk_all_zero("rst_mid");
      @(posedge clk); #1;
      @(negedge clk);
      rst      = 1'b0;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      chk_all_zero("rst_after");

      // Randomized op mix
      for (int i = 0; i < 60; i++) begin
         a = 32'h100 + 32'($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         kind = int'($urandom_range(0, 2));
         case (kind)
            0: drive_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            1: do_mem(1'b0, 1'b0, a, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            default: do_mem(1'b1, 1'($urandom_range(0, 1)), a, $urandom,
                            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 3)));
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
